// File: rtl/rf_wb_arbiter_pkg.sv
// Shared constants for the register-file write-back arbiter.
package rf_wb_arbiter_pkg;

   localparam int NREQ = 3;   // requesters: ALU, MEM, DBG
   localparam int AW   = 5;   // register address width
   localparam int DW   = 32;  // register data width
   localparam int IDW  = 2;   // width of a requester index

   localparam int REQ_ALU = 0;
   localparam int REQ_MEM = 1;
   localparam int REQ_DBG = 2;

   // Writes to x0 are accepted but never reach the register file
   localparam logic [AW-1:0] X0 = '0;

endpackage

// File: rtl/rf_wb_arbiter_rr_arbiter.sv
// Round-robin arbiter: one-hot grant per cycle, pointer rotates past the winner.
module rr_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int N  = NREQ,
   parameter int IW = IDW
) (
   input  logic          clk,
   input  logic          rst,
   input  logic [N-1:0]  valid,
   input  logic          hold,
   output logic [N-1:0]  grant,
   output logic [IW-1:0] grant_idx,
   output logic          grant_any
);

   logic [IW-1:0] ptr;
   int            cand;
   logic          found;

   // Search ptr, ptr+1, ... (mod N) for the first valid requester; hold and reset mask all grants
   always_comb begin
      grant     = '0;
      grant_idx = '0;
      found     = 1'b0;
      cand      = 0;
      if (!rst && !hold) begin
         for (int k = 0; k < N; k++) begin
            cand = int'(ptr) + k;
            if (cand >= N) cand = cand - N;
            if (!found && valid[cand]) begin
               found       = 1'b1;
               grant[cand] = 1'b1;
               grant_idx   = IW'(cand);
            end
         end
      end
   end

   assign grant_any = found;

   // Rotate the pointer to just past the winner; unchanged when nothing is granted
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         ptr <= '0;
      else if (grant_any)
         ptr <= (grant_idx == IW'(N-1)) ? '0 : grant_idx + 1'b1;
   end

endmodule

// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter: shares the single register-file write port between ALU, MEM and DBG.
module rf_wb_arbiter
   import rf_wb_arbiter_pkg::*;
#(
   parameter int NREQ_P = NREQ,
   parameter int AW_P   = AW,
   parameter int DW_P   = DW
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ_P-1:0]      req_valid,
   output logic [NREQ_P-1:0]      req_ready,
   input  logic [NREQ_P*AW_P-1:0] req_wa,
   input  logic [NREQ_P*DW_P-1:0] req_wd,
   input  logic                   hold,
   output logic                   rf_we,
   output logic [AW_P-1:0]        rf_wa,
   output logic [DW_P-1:0]        rf_wd,
   output logic [1:0]             grant_id,
   output logic [31:0]            busy,
   output logic [31:0]            wb_count
);

   logic [1:0]      gnt_idx;
   logic            gnt_any;
   logic [AW_P-1:0] sel_wa;
   logic [DW_P-1:0] sel_wd;
   logic [31:0]     wb_count_q;

   rr_arbiter #(.N(NREQ_P), .IW(2)) u_arb (
      .clk       (clk),
      .rst       (rst),
      .valid     (req_valid),
      .hold      (hold),
      .grant     (req_ready),
      .grant_idx (gnt_idx),
      .grant_any (gnt_any)
   );

   // Select the winner's destination and data
   always_comb begin
      sel_wa = req_wa[int'(gnt_idx)*AW_P +: AW_P];
      sel_wd = req_wd[int'(gnt_idx)*DW_P +: DW_P];
   end

   // One-entry output stage; x0 destinations are accepted but leave rf_we low
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rf_we    <= 1'b0;
         rf_wa    <= '0;
         rf_wd    <= '0;
         grant_id <= '0;
      end else if (gnt_any) begin
         rf_we    <= (sel_wa != X0);
         rf_wa    <= sel_wa;
         rf_wd    <= sel_wd;
         grant_id <= gnt_idx;
      end else begin
         rf_we    <= 1'b0;
      end
   end

   // Count committed writes; wraps naturally at 2^32
   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         wb_count_q <= '0;
      else
         wb_count_q <= wb_count_q + 32'(rf_we);
   end

   assign wb_count = wb_count_q;

   // Scoreboard bit of the register currently being written
   always_comb begin
      busy = rf_we ? (32'd1 << rf_wa) : 32'd0;
   end

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Scoreboard bench for rf_wb_arbiter: driver pushes expected commits, monitor pops on rf_we.
module tb_rf_wb_arbiter;

   logic        clk = 1'b0;
   logic        rst;
   logic [2:0]  req_valid;
   logic [2:0]  req_ready;
   logic [14:0] req_wa;
   logic [95:0] req_wd;
   logic        hold;
   logic        rf_we;
   logic [4:0]  rf_wa;
   logic [31:0] rf_wd;
   logic [1:0]  grant_id;
   logic [31:0] busy;
   logic [31:0] wb_count;

   typedef struct {
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [1:0]  gid;
      logic [31:0] busy;
      logic [31:0] cnt;
   } exp_t;

   exp_t        q[$];
   int          total = 0;
   int          bad   = 0;
   logic [31:0] exp_cnt;

   rf_wb_arbiter dut (
      .clk       (clk),
      .rst       (rst),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_wa    (req_wa),
      .req_wd    (req_wd),
      .hold      (hold),
      .rf_we     (rf_we),
      .rf_wa     (rf_wa),
      .rf_wd     (rf_wd),
      .grant_id  (grant_id),
      .busy      (busy),
      .wb_count  (wb_count)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   // One cycle of stimulus: drive at negedge, check ready, queue the expected commit
   task automatic drive(input logic [2:0] v, input logic [14:0] wa, input logic [95:0] wd,
                        input logic h, input logic [2:0] exp_rdy, input logic push);
      exp_t e;
      logic [4:0] a;
      @(negedge clk);
      req_valid = v;
      req_wa    = wa;
      req_wd    = wd;
      hold      = h;
      #1;
      chk("req_ready", 32'(req_ready), 32'(exp_rdy));
      for (int i = 0; i < 3; i++) begin
         if (exp_rdy[i]) begin
            a = wa[i*5 +: 5];
            if (push && a != 5'd0) begin
               e.wa   = a;
               e.wd   = wd[i*32 +: 32];
               e.gid  = 2'(i);
               e.busy = 32'd1 << a;
               e.cnt  = exp_cnt;
               q.push_back(e);
               exp_cnt = exp_cnt + 1;
            end
         end
      end
   endtask

   // Monitor: every presented write must match the oldest queued expectation
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rf_we === 1'b1) begin
            if (q.size() == 0) begin
               total++;
               bad++;
               $display("FAIL unexpected_write: rf_wa=%0d rf_wd=0x%0h, no write expected", rf_wa, rf_wd);
            end else begin
               e = q.pop_front();
               chk("rf_wa", 32'(rf_wa), 32'(e.wa));
               chk("rf_wd", rf_wd, e.wd);
               chk("grant_id", 32'(grant_id), 32'(e.gid));
               chk("busy", busy, e.busy);
               chk("wb_count", wb_count, e.cnt);
            end
         end
      end
   end

   // Watchdog
   initial begin
      #100000;
      $display("FAIL watchdog: time limit reached");
      $fatal(1, "timeout");
   end

   initial begin
      rst       = 1'b1;
      req_valid = 3'b111;
      req_wa    = {5'd3, 5'd2, 5'd1};
      req_wd    = '0;
      hold      = 1'b0;
      exp_cnt   = 32'd0;

      // Reset state, ready masked even with all valid
      @(negedge clk); #1;
      chk("rst_rf_we", 32'(rf_we), 32'd0);
      chk("rst_rf_wa", 32'(rf_wa), 32'd0);
      chk("rst_rf_wd", rf_wd, 32'd0);
      chk("rst_grant_id", 32'(grant_id), 32'd0);
      chk("rst_busy", busy, 32'd0);
      chk("rst_wb_count", wb_count, 32'd0);
      chk("rst_ready", 32'(req_ready), 32'd0);
      req_valid = 3'b000;
      rst = 1'b0;

      // ALU wa=5 wd=0x1234
      drive(3'b001, {5'd0, 5'd0, 5'd5}, {32'd0, 32'd0, 32'h1234}, 1'b0, 3'b001, 1'b1);
      drive(3'b000, '0, '0, 1'b0, 3'b000, 1'b1);

      // MEM write to x0: accepted, never committed (ptr now 1)
      drive(3'b010, '0, {32'd0, 32'hFFFF, 32'd0}, 1'b0, 3'b010, 1'b1);
      drive(3'b000, '0, '0, 1'b0, 3'b000, 1'b1);
      chk("x0_rf_we", 32'(rf_we), 32'd0);
      chk("x0_busy", busy, 32'd0);
      chk("x0_wb_count", wb_count, 32'd1);

      // DBG wa=7 under hold for 4 cycles, then granted when hold drops
      repeat (4) drive(3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'd0, 32'd0}, 1'b1, 3'b000, 1'b1);
      drive(3'b100, {5'd7, 5'd0, 5'd0}, {32'h77, 32'd0, 32'd0}, 1'b0, 3'b100, 1'b1);

      // All three valid from ptr=0: 0,1,2,0,1,2
      for (int k = 0; k < 6; k++)
         drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'hA3, 32'hA2, 32'hA1}, 1'b0, 3'b001 << (k % 3), 1'b1);
      // Hold right after a grant: no new grant, last entry still commits
      drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'hA3, 32'hA2, 32'hA1}, 1'b1, 3'b000, 1'b1);
      drive(3'b000, '0, '0, 1'b0, 3'b000, 1'b1);

      // Counter wrap: preset to all-ones, then one commit
      force dut.wb_count_q = 32'hFFFF_FFFF;
      @(posedge clk);
      @(negedge clk);
      release dut.wb_count_q;
      #1;
      chk("preset_wb_count", wb_count, 32'hFFFF_FFFF);
      exp_cnt = 32'hFFFF_FFFF;
      drive(3'b001, {5'd0, 5'd0, 5'd4}, {32'd0, 32'd0, 32'h44}, 1'b0, 3'b001, 1'b1);
      drive(3'b000, '0, '0, 1'b0, 3'b000, 1'b1);
      drive(3'b000, '0, '0, 1'b0, 3'b000, 1'b1);
      chk("wrap_wb_count", wb_count, 32'd0);

      // Reset mid-operation discards the staged write to r9 (ptr is 1 here)
      drive(3'b001, {5'd0, 5'd0, 5'd9}, {32'd0, 32'd0, 32'h99}, 1'b0, 3'b001, 1'b0);
      @(posedge clk); #1;
      chk("staged_rf_we", 32'(rf_we), 32'd1);
      chk("staged_rf_wa", 32'(rf_wa), 32'd9);
      rst = 1'b1;
      #1;
      chk("async_rf_we", 32'(rf_we), 32'd0);
      chk("async_busy", busy, 32'd0);
      chk("async_wb_count", wb_count, 32'd0);
      chk("async_ready", 32'(req_ready), 32'd0);
      @(negedge clk);
      req_valid = 3'b000;
      rst = 1'b0;
      exp_cnt = 32'd0;

      // Pointer back at 0 after reset
      drive(3'b111, {5'd3, 5'd2, 5'd1}, {32'hA3, 32'hA2, 32'hA1}, 1'b0, 3'b001, 1'b1);
      drive(3'b000, '0, '0, 1'b0, 3'b000, 1'b1);
      drive(3'b000, '0, '0, 1'b0, 3'b000, 1'b1);
      chk("queue_empty", 32'(q.size()), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
